// File: rtl/handshake_source.sv
// Two-entry valid/ready source buffer: accepts (in1, in2), queues
// {AND-reduce flag, in1 ^ in2} in order and counts completed output transfers.
//
// state | meaning
// EMPTY | no buffered word, out_valid low
// ONE   | one word at head, can accept and emit
// FULL  | two words buffered, in_ready low
module handshake_source #(
    parameter int DEPTH = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in1,
    input  logic [3:0] in2,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_data,
    output logic       out_flag,
    output logic [1:0] occupancy,
    output logic [7:0] tx_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [1:0] FULL_OCC = 2'(DEPTH);

    state_t     state;
    state_t     state_nxt;
    logic [4:0] head;
    logic [4:0] head_nxt;
    logic [4:0] tail;
    logic [4:0] tail_nxt;
    logic [4:0] word;
    logic       push;
    logic       pop;

    // Entry layout: {flag, payload}
    assign word      = {(|in1) & (&in1), in1 ^ in2};
    assign occupancy = state;
    assign in_ready  = (occupancy != FULL_OCC);
    assign out_valid = (occupancy != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_data  = RESET ? 4'd0 : head[3:0];
    assign out_flag  = RESET ? 1'b0 : head[4];

    always_comb begin
        state_nxt = state;
        head_nxt  = head;
        tail_nxt  = tail;
        case (state)
            EMPTY: begin
                if (push) begin
                    state_nxt = ONE;
                    head_nxt  = word;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_nxt = word;
                end else if (push) begin
                    state_nxt = FULL;
                    tail_nxt  = word;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_nxt = ONE;
                    head_nxt  = tail;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= EMPTY;
            head     <= '0;
            tail     <= '0;
            tx_count <= 8'd0;
        end else begin
            state <= state_nxt;
            head  <= head_nxt;
            tail  <= tail_nxt;
            if (pop) begin
                tx_count <= tx_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_handshake_source.sv
// Bench for handshake_source: directed scenarios plus random traffic, checked
// against a queue-based reference of the buffer contents and transfer count.
module tb_handshake_source;

    logic       CLK;
    logic       RESET;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in1;
    logic [3:0] in2;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       out_flag;
    logic [1:0] occupancy;
    logic [7:0] tx_count;

    handshake_source #(.DEPTH(2)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flag  (out_flag),
        .occupancy (occupancy),
        .tx_count  (tx_count)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    logic [4:0] q[$];
    int         exp_tx;
    int         n_cmp;
    int         n_bad;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        check("occupancy", 8'(occupancy), 8'(q.size()));
        check("in_ready", 8'(in_ready), 8'(q.size() != 2));
        check("out_valid", 8'(out_valid), 8'(q.size() != 0));
        check("tx_count", tx_count, 8'(exp_tx));
        if (RESET) begin
            check("rst_data", 8'(out_data), 8'd0);
            check("rst_flag", 8'(out_flag), 8'd0);
        end else if (q.size() > 0) begin
            check("out_data", 8'(out_data), 8'(q[0][3:0]));
            check("out_flag", 8'(out_flag), 8'(q[0][4]));
        end
    endtask

    // One clock: drive inputs, advance the reference on the edge, check after it.
    task automatic cycle(input logic iv, input logic [3:0] a, input logic [3:0] b,
                         input logic ordy, input logic rst);
        int sz;
        in_valid  = iv;
        in1       = a;
        in2       = b;
        out_ready = ordy;
        RESET     = rst;
        @(posedge CLK);
        sz = q.size();
        if (rst) begin
            q.delete();
            exp_tx = 0;
        end else begin
            if (ordy && sz > 0) begin
                void'(q.pop_front());
                exp_tx = (exp_tx + 1) % 256;
            end
            if (iv && sz < 2) begin
                q.push_back({(a == 4'hF), a ^ b});
            end
        end
        #1;
        check_model();
    endtask

    function automatic logic [3:0] r4();
        return 4'($urandom);
    endfunction

    initial begin
        logic [7:0] t0;
        logic       pv;
        logic [3:0] pd;
        logic       pf;
        logic       ordy;
        logic       rst;
        n_cmp     = 0;
        n_bad     = 0;
        exp_tx    = 0;
        RESET     = 1'b1;
        in_valid  = 1'b0;
        in1       = 4'd0;
        in2       = 4'd0;
        out_ready = 1'b0;

        cycle(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
        cycle(1'b1, 4'hF, 4'hF, 1'b1, 1'b1);
        check("reset_in_ready", 8'(in_ready), 8'd1);

        // single word
        cycle(1'b1, 4'hF, 4'h3, 1'b1, 1'b0);
        check("sw_valid", 8'(out_valid), 8'd1);
        check("sw_data", 8'(out_data), 8'hC);
        check("sw_flag", 8'(out_flag), 8'd1);
        cycle(1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
        check("sw_tx", tx_count, 8'd1);

        // backpressure
        cycle(1'b1, 4'h1, 4'h0, 1'b0, 1'b0);
        cycle(1'b1, 4'h2, 4'h0, 1'b0, 1'b0);
        check("bp_occ", 8'(occupancy), 8'd2);
        check("bp_in_ready", 8'(in_ready), 8'd0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, r4(), r4(), 1'b0, 1'b0);
            check("bp_hold_data", 8'(out_data), 8'h1);
            check("bp_hold_flag", 8'(out_flag), 8'd0);
        end
        cycle(1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
        check("bp_second", 8'(out_data), 8'h2);
        cycle(1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
        check("bp_drained", 8'(occupancy), 8'd0);

        // simultaneous push/pop at occupancy 1
        cycle(1'b1, r4(), r4(), 1'b0, 1'b0);
        t0 = tx_count;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, r4(), r4(), 1'b1, 1'b0);
            check("pp_occ", 8'(occupancy), 8'd1);
        end
        check("pp_tx", tx_count, t0 + 8'd20);

        // tx_count wrap
        cycle(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
        cycle(1'b1, r4(), r4(), 1'b0, 1'b0);
        for (int i = 0; i < 256; i++) begin
            cycle(1'b1, r4(), r4(), 1'b1, 1'b0);
        end
        check("wrap_tx", tx_count, 8'd0);

        // reset while FULL with a pop pending
        cycle(1'b1, r4(), r4(), 1'b0, 1'b0);
        check("full_occ", 8'(occupancy), 8'd2);
        cycle(1'b1, r4(), r4(), 1'b1, 1'b1);
        check("rf_occ", 8'(occupancy), 8'd0);
        check("rf_valid", 8'(out_valid), 8'd0);
        check("rf_tx", tx_count, 8'd0);
        cycle(1'b1, 4'h5, 4'h6, 1'b0, 1'b0);
        check("post_rst_occ", 8'(occupancy), 8'd1);
        check("post_rst_data", 8'(out_data), 8'h3);

        // random traffic with stall-stability property
        for (int i = 0; i < 400; i++) begin
            pv   = out_valid;
            pd   = out_data;
            pf   = out_flag;
            ordy = 1'($urandom);
            rst  = ($urandom_range(0, 49) == 0);
            cycle(1'($urandom), r4(), r4(), ordy, rst);
            if (pv && !ordy && !rst) begin
                check("stable_valid", 8'(out_valid), 8'(pv));
                check("stable_data", 8'(out_data), 8'(pd));
                check("stable_flag", 8'(out_flag), 8'(pf));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/handshake_source.md
HANDSHAKE_SOURCE -- requirements
Module: handshake_source

Interface
- REQ-001: The module SHALL have one parameter: DEPTH, default 2, the number of buffer entries; the only legal value is 2.
- REQ-002: The module SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
- REQ-003: The module SHALL have port RESET  input  1  synchronous, active-high reset, sampled on the rising edge of CLK.
- REQ-004: The module SHALL have port in_valid  input  1  the upstream producer has a word on in1/in2.
- REQ-005: The module SHALL have port in_ready  output  1  the block can accept a word this cycle.
- REQ-006: The module SHALL have port in1  input  4  operand A.
- REQ-007: The module SHALL have port in2  input  4  operand B.
- REQ-008: The module SHALL have port out_valid  output  1  transmit-side valid (the handshake_valid end of the link).
- REQ-009: The module SHALL have port out_ready  input  1  the receiver accepts a word (the handshake_ready end of the link).
- REQ-010: The module SHALL have port out_data  output  4  transmitted payload.
- REQ-011: The module SHALL have port out_flag  output  1  transmitted reduction flag.
- REQ-012: The module SHALL have port occupancy  output  2  number of buffered words, 0..2.
- REQ-013: The module SHALL have port tx_count  output  8  count of completed output transfers.

Function
- REQ-014: An input transfer SHALL occur in any cycle with in_valid=1 and in_ready=1; an output transfer SHALL occur in any cycle with out_valid=1 and out_ready=1.
- REQ-015: On an input transfer, the block SHALL buffer payload = in1 XOR in2 and flag = (OR-reduce in1) AND (AND-reduce in1).
- REQ-016: in_ready SHALL equal (occupancy != 2), derived from registered state only, with no combinational path from out_ready.
- REQ-017: out_valid SHALL equal (occupancy != 0), derived from registered state only, with no combinational path from in_valid.
- REQ-018: out_data and out_flag SHALL always present the oldest buffered entry.
- REQ-019: Words SHALL leave the block in arrival order, with no loss and no duplication.
- REQ-020: The block SHALL have no same-cycle bypass: a word accepted in cycle N SHALL be first visible on out_valid/out_data in cycle N+1 at the earliest.
- REQ-021: While out_valid=1 and out_ready=0, out_valid, out_data and out_flag SHALL hold stable until the transfer completes.
- REQ-022: occupancy SHALL behave as a three-state machine: EMPTY(0), ONE(1), FULL(2).
- REQ-023: In EMPTY, an input transfer SHALL move the state to ONE; otherwise the state SHALL stay EMPTY.
- REQ-024: In ONE, an input transfer alone SHALL move to FULL, an output transfer alone SHALL move to EMPTY, and both together SHALL stay ONE, with the new word queued behind the departing one.
- REQ-025: In FULL, an output transfer SHALL move to ONE; in_ready=0, so no input transfer occurs in FULL.
- REQ-026: tx_count SHALL increment by 1 on each output transfer and wrap from 255 to 0 without saturating.
- REQ-027: in_valid=1 while in_ready=0 SHALL have no effect on any state.

Reset
- REQ-028: While RESET=1 at a clock edge, the block SHALL set occupancy=0, tx_count=0, out_valid=0 and in_ready=1, and discard all buffered data.
- REQ-029: While RESET=1, out_data and out_flag SHALL be 0.
- REQ-030: Reset asserted mid-operation, including in FULL with a transfer pending, SHALL flush without emitting a word.
- REQ-031: No transfer SHALL be counted in a cycle where RESET=1.
- REQ-032: When RESET is sampled high, it SHALL override any simultaneous input or output transfer.
- REQ-033: In the first cycle after RESET deasserts, the block SHALL accept input normally.

Verification
- REQ-034: The bench SHALL check single word: reset; then in1=4'hF, in2=4'h3 with in_valid=1 and out_ready=1 -> next cycle out_valid=1, out_data=4'hC, out_flag=1, then tx_count=1.
- REQ-035: The bench SHALL check backpressure: out_ready=0, push in1=4'h1/in2=4'h0 then in1=4'h2/in2=4'h0 -> occupancy=2, in_ready=0, out_data held at 4'h1 with out_flag=0 for 10 cycles; then out_ready=1 -> 4'h1, then 4'h2 in order.
- REQ-036: The bench SHALL check simultaneous push/pop at occupancy=1 for 20 cycles -> occupancy stays 1, every word delivered in order, and tx_count advances by 20.
- REQ-037: The bench SHALL check wrap: 256 output transfers -> tx_count returns to 0.
- REQ-038: The bench SHALL check reset in FULL with out_ready=1 -> next cycle occupancy=0, out_valid=0, tx_count=0, and no transfer counted.
- REQ-039: The bench SHALL check random stimulus against the stability property: out_valid=1 and out_ready=0 in cycle N -> identical out_valid, out_data and out_flag in cycle N+1.
